// File: rtl/req_ack_pkg.sv
// Shared types and limits for the req/ack responder stage.
package req_ack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned ACK_DLY_MIN    = 1;
  localparam int unsigned ACK_DLY_MAX    = 3;
  localparam int unsigned DATA_W_DEFAULT = 8;

endpackage

// File: rtl/req_ack_responder.sv
// Answers a level req/data handshake with a delayed one-cycle ack, forwards
// non-zero payloads to a valid/ready consumer and flags zero data or aborts.
module req_ack_responder
  import req_ack_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned ACK_DLY = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic [DATA_W-1:0] req_data,
  output logic              ack,
  output logic              valid,
  output logic [DATA_W-1:0] data_out,
  input  logic              out_ready,
  output logic              error,
  output logic              busy,
  output logic [CNT_W-1:0]  xfer_cnt
);

  localparam int unsigned DLY_W = 2;
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(ACK_DLY - 1);

  if (ACK_DLY < ACK_DLY_MIN || ACK_DLY > ACK_DLY_MAX) begin : g_bad_ack_dly
    $error("req_ack_responder: ACK_DLY must be within 1..3");
  end

  state_e              state_q, state_d;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                ack_q, ack_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                error_q, error_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                slot_free;
  logic                handshake;

  assign handshake = valid_q && out_ready;
  assign slot_free = !valid_q || out_ready;

  // Next-state, delay counter and output-slot computation.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    hold_d  = hold_q;
    ack_d   = 1'b0;
    error_d = 1'b0;
    valid_d = handshake ? 1'b0 : valid_q;
    data_d  = data_q;
    cnt_d   = (handshake && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          hold_d = req_data;
          dly_d  = DLY_LOAD;
          state_d = ((ACK_DLY == 1) && slot_free) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!req) begin
          // Abort outranks any pending stall.
          error_d = 1'b1;
          dly_d   = '0;
          state_d = IDLE;
        end else if (dly_q > DLY_W'(1)) begin
          dly_d = dly_q - DLY_W'(1);
        end else begin
          dly_d = '0;
          if (slot_free) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs of the response cycle are registered on the edge into RESP.
    if (state_d == RESP) begin
      ack_d = 1'b1;
      if (hold_d != '0) begin
        valid_d = 1'b1;
        data_d  = hold_d;
      end else begin
        error_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dly_q   <= '0;
      hold_q  <= '0;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      hold_q  <= hold_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      error_q <= error_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ack      = ack_q;
  assign valid    = valid_q;
  assign data_out = data_q;
  assign error    = error_q;
  assign busy     = busy_q;
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_req_ack_responder.sv
// Directed checks of req_ack_responder across ACK_DLY = 1, 2 and 3 instances.
module tb_req_ack_responder;

  logic       clk;
  logic       reset_n;
  logic [7:0] req_data;
  logic       out_ready;

  logic        req2, ack2, valid2, error2, busy2;
  logic [7:0]  data2;
  logic [15:0] cnt2;

  logic        req1, ack1, valid1, error1, busy1;
  logic [7:0]  data1;
  logic [3:0]  cnt1;

  logic        req3, ack3, valid3, error3, busy3;
  logic [7:0]  data3;
  logic [15:0] cnt3;

  int tests;
  int fails;

  req_ack_responder #(.DATA_W(8), .ACK_DLY(2), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .req(req2), .req_data(req_data),
    .ack(ack2), .valid(valid2), .data_out(data2), .out_ready(out_ready),
    .error(error2), .busy(busy2), .xfer_cnt(cnt2)
  );

  req_ack_responder #(.DATA_W(8), .ACK_DLY(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .req(req1), .req_data(req_data),
    .ack(ack1), .valid(valid1), .data_out(data1), .out_ready(out_ready),
    .error(error1), .busy(busy1), .xfer_cnt(cnt1)
  );

  req_ack_responder #(.DATA_W(8), .ACK_DLY(3), .CNT_W(16)) dut3 (
    .clk(clk), .reset_n(reset_n), .req(req3), .req_data(req_data),
    .ack(ack3), .valid(valid3), .data_out(data3), .out_ready(out_ready),
    .error(error3), .busy(busy3), .xfer_cnt(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req1 = 0; req2 = 0; req3 = 0;
    req_data = 8'h00; out_ready = 1'b1;
    tick(); tick();
    tests++;
    if ({ack2, valid2, error2, busy2, data2, cnt2} !== 28'h0) begin
      $display("FAIL reset_dut2: got %h want 0", {ack2, valid2, error2, busy2, data2, cnt2}); fails++;
    end
    tests++;
    if ({ack1, valid1, error1, busy1, data1, cnt1, ack3, busy3} !== 18'h0) begin
      $display("FAIL reset_dut1_dut3: got %h want 0", {ack1, valid1, error1, busy1, data1, cnt1, ack3, busy3}); fails++;
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    req2 = 1'b1; req_data = 8'h5A; out_ready = 1'b1;
    tick();
    tests++;
    if ({ack2, busy2, valid2} !== 3'b010) begin
      $display("FAIL basic_c1: got ack/busy/valid=%b want 010", {ack2, busy2, valid2}); fails++;
    end
    tick();
    tests++;
    if ({ack2, valid2, error2} !== 3'b110 || data2 !== 8'h5A) begin
      $display("FAIL basic_c2: got avE=%b data=%h want 110 5a", {ack2, valid2, error2}, data2); fails++;
    end
    req2 = 1'b0;
    tick();
    tests++;
    if ({ack2, valid2, busy2} !== 3'b000 || cnt2 !== 16'd1 || data2 !== 8'h5A) begin
      $display("FAIL basic_c3: got avb=%b cnt=%0d data=%h want 000 1 5a", {ack2, valid2, busy2}, cnt2, data2); fails++;
    end
  endtask

  task automatic test_zero_data();
    req2 = 1'b1; req_data = 8'h00;
    tick(); tick();
    tests++;
    if ({ack2, error2, valid2} !== 3'b110) begin
      $display("FAIL zero_c2: got ack/err/valid=%b want 110", {ack2, error2, valid2}); fails++;
    end
    req2 = 1'b0;
    tick();
    tests++;
    if ({ack2, error2, valid2} !== 3'b000 || cnt2 !== 16'd1) begin
      $display("FAIL zero_c3: got aev=%b cnt=%0d want 000 1", {ack2, error2, valid2}, cnt2); fails++;
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0; req2 = 1'b1; req_data = 8'h11;
    tick(); tick();
    tests++;
    if ({ack2, valid2} !== 2'b11 || data2 !== 8'h11) begin
      $display("FAIL stall_first: got ack/valid=%b data=%h want 11 11", {ack2, valid2}, data2); fails++;
    end
    req2 = 1'b0;
    tick();
    req2 = 1'b1; req_data = 8'h22;
    for (int c = 4; c <= 6; c++) begin
      tick();
      tests++;
      if ({ack2, busy2, valid2} !== 3'b011 || data2 !== 8'h11) begin
        $display("FAIL stall_wait_c%0d: got abv=%b data=%h want 011 11", c, {ack2, busy2, valid2}, data2); fails++;
      end
    end
    out_ready = 1'b1;
    tick();
    tests++;
    if ({ack2, valid2} !== 2'b11 || data2 !== 8'h22 || cnt2 !== 16'd2) begin
      $display("FAIL stall_resp: got av=%b data=%h cnt=%0d want 11 22 2", {ack2, valid2}, data2, cnt2); fails++;
    end
    req2 = 1'b0;
    tick();
    tests++;
    if ({ack2, valid2} !== 2'b00 || cnt2 !== 16'd3) begin
      $display("FAIL stall_drain: got av=%b cnt=%0d want 00 3", {ack2, valid2}, cnt2); fails++;
    end
  endtask

  task automatic test_abort();
    req3 = 1'b1; req_data = 8'h44;
    tick();
    tests++;
    if ({busy3, ack3, error3} !== 3'b100) begin
      $display("FAIL abort_c1: got busy/ack/err=%b want 100", {busy3, ack3, error3}); fails++;
    end
    req3 = 1'b0;
    tick();
    tests++;
    if ({error3, busy3, ack3, valid3} !== 4'b1000) begin
      $display("FAIL abort_c2: got err/busy/ack/valid=%b want 1000", {error3, busy3, ack3, valid3}); fails++;
    end
    for (int c = 3; c <= 5; c++) begin
      tick();
      tests++;
      if ({error3, busy3, ack3, valid3} !== 4'b0000) begin
        $display("FAIL abort_after_c%0d: got %b want 0000", c, {error3, busy3, ack3, valid3}); fails++;
      end
    end
  endtask

  task automatic test_async_reset();
    req2 = 1'b1; req_data = 8'h33;
    tick();
    tests++;
    if (busy2 !== 1'b1) begin
      $display("FAIL areset_busy: got %b want 1", busy2); fails++;
    end
    #3;
    reset_n = 1'b0; req2 = 1'b0;
    #1;
    tests++;
    if ({ack2, valid2, error2, busy2, data2, cnt2} !== 28'h0) begin
      $display("FAIL areset_immediate: got %h want 0", {ack2, valid2, error2, busy2, data2, cnt2}); fails++;
    end
    tick(); tick();
    #2;
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests++;
      if ({ack2, error2, busy2, valid2} !== 4'b0000) begin
        $display("FAIL areset_quiet_c%0d: got %b want 0000", c, {ack2, error2, busy2, valid2}); fails++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] cur;
    logic       exp_ack;
    cur = 8'h01;
    out_ready = 1'b1; req_data = cur; req1 = 1'b1;
    for (int k = 0; k < 40; k++) begin
      exp_ack = (k % 2) == 1;
      tests++;
      if (ack1 !== exp_ack || error1 !== 1'b0) begin
        $display("FAIL b2b_ack_c%0d: got ack=%b err=%b want %b 0", k, ack1, error1, exp_ack); fails++;
      end
      if (exp_ack) begin
        tests++;
        if (valid1 !== 1'b1 || data1 !== cur) begin
          $display("FAIL b2b_data_c%0d: got valid=%b data=%h want 1 %h", k, valid1, data1, cur); fails++;
        end
        cur = cur + 8'd1;
        req_data = cur;
      end
      if (k == 29 || k == 30 || k == 38) begin
        tests++;
        if (cnt1 !== ((k == 29) ? 4'd14 : 4'd15)) begin
          $display("FAIL b2b_cnt_c%0d: got %0d want %0d", k, cnt1, (k == 29) ? 14 : 15); fails++;
        end
      end
      tick();
    end
    req1 = 1'b0;
    tests++;
    if (cnt1 !== 4'd15) begin
      $display("FAIL b2b_saturate: got %0d want 15", cnt1); fails++;
    end
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_zero_data();
    test_stall();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
